// File: rtl/gol_engine.sv
`default_nettype none
// ============================================================================
// Module   : gol_engine
// Purpose  : Conway Game-of-Life (B3/S23) generation engine. Holds a
//            ROWS x COLS grid, computes one generation per step request at
//            one row per clock into a shadow buffer, then commits the whole
//            generation in a single edge so readers never see a torn grid.
// Ports    : clk        - system clock, all state on the rising edge
//            rst_n      - synchronous active-low reset
//            step       - request one generation (sampled in IDLE only)
//            busy       - high while a generation is in progress
//            done       - one-cycle pulse, new generation readable
//            load_en    - write load_data into row load_row (IDLE only)
//            load_row   - row index for load
//            load_data  - row contents, bit c = column c, 1 = alive
//            rd_row     - display read row index
//            rd_data    - committed grid[rd_row], 0 when out of range
//            gen_count  - committed generations, wraps modulo 2^GEN_W
//            stable     - last commit equal to its predecessor
//            extinct    - committed grid all zero after last step
// Revision : 1.0 - initial release
// ============================================================================
module gol_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step,
  output logic                    busy,
  output logic                    done,
  input  logic                    load_en,
  input  logic [$clog2(ROWS)-1:0] load_row,
  input  logic [COLS-1:0]         load_data,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data,
  output logic [GEN_W-1:0]        gen_count,
  output logic                    stable,
  output logic                    extinct
);

  localparam int RW = $clog2(ROWS);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COMPUTE = 2'd1;
  localparam logic [1:0] c_COMMIT  = 2'd2;

  // One extra bit so ROWS itself is representable for range checks.
  localparam logic [RW:0]    c_ROWS    = (RW+1)'(ROWS);
  localparam logic [RW-1:0]  c_LAST    = RW'(ROWS - 1);
  localparam logic [RW-1:0]  c_ONE     = RW'(1);
  localparam logic [GEN_W-1:0] c_GEN_ONE = GEN_W'(1);

  logic [1:0]                  state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]   grid_q;
  logic [ROWS-1:0][COLS-1:0]   shadow_q;
  logic [RW-1:0]               row_q;
  logic [GEN_W-1:0]            gen_q;
  logic                        done_q;
  logic                        stable_q;
  logic                        extinct_q;

  logic [COLS-1:0]             w_up_row;
  logic [COLS-1:0]             w_cur_row;
  logic [COLS-1:0]             w_dn_row;
  logic [COLS-1:0]             w_next_row;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:    if (step) state_d = c_COMPUTE;
      c_COMPUTE: if (row_q == c_LAST) state_d = c_COMMIT;
      c_COMMIT:  state_d = c_IDLE;
      default:   state_d = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != c_IDLE);
    done      = done_q;
    gen_count = gen_q;
    stable    = stable_q;
    extinct   = extinct_q;
    rd_data   = '0;
    if ({1'b0, rd_row} < c_ROWS) rd_data = grid_q[rd_row];
  end

  // --------------------------------------------------------------------------
  // Neighbourhood rows for the row being computed. With dead edges the
  // missing row above/below is simply all-zero.
  // --------------------------------------------------------------------------
  always_comb begin
    w_up_row  = '0;
    w_dn_row  = '0;
    w_cur_row = grid_q[row_q];
    if (row_q == '0) begin
      if (WRAP != 0) w_up_row = grid_q[ROWS-1];
    end else begin
      w_up_row = grid_q[row_q - c_ONE];
    end
    if (row_q == c_LAST) begin
      if (WRAP != 0) w_dn_row = grid_q[0];
    end else begin
      w_dn_row = grid_q[row_q + c_ONE];
    end
  end

  // --------------------------------------------------------------------------
  // Per-column B3/S23 rule. Column wrap is resolved at elaboration time, so
  // each cell sees a fixed set of eight neighbour taps (some tied to 0).
  // --------------------------------------------------------------------------
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL    = (c == 0) ? COLS - 1 : c - 1;
    localparam int CR    = (c == COLS - 1) ? 0 : c + 1;
    localparam bit HAS_L = (WRAP != 0) || (c != 0);
    localparam bit HAS_R = (WRAP != 0) || (c != COLS - 1);

    logic       w_ul, w_u, w_ur, w_l, w_r, w_dl, w_d, w_dr;
    logic [3:0] w_cnt;

    assign w_ul = HAS_L ? w_up_row[CL]  : 1'b0;
    assign w_u  = w_up_row[c];
    assign w_ur = HAS_R ? w_up_row[CR]  : 1'b0;
    assign w_l  = HAS_L ? w_cur_row[CL] : 1'b0;
    assign w_r  = HAS_R ? w_cur_row[CR] : 1'b0;
    assign w_dl = HAS_L ? w_dn_row[CL]  : 1'b0;
    assign w_d  = w_dn_row[c];
    assign w_dr = HAS_R ? w_dn_row[CR]  : 1'b0;

    assign w_cnt = 4'(w_ul) + 4'(w_u) + 4'(w_ur) + 4'(w_l)
                 + 4'(w_r)  + 4'(w_dl) + 4'(w_d) + 4'(w_dr);

    assign w_next_row[c] = (w_cnt == 4'd3) || ((w_cnt == 4'd2) && w_cur_row[c]);
  end

  // --------------------------------------------------------------------------
  // Datapath: loads, shadow fill, atomic commit and status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grid_q    <= '0;
      shadow_q  <= '0;
      row_q     <= '0;
      gen_q     <= '0;
      done_q    <= 1'b0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        c_IDLE: begin
          // A load coinciding with step lands before the first row is read.
          if (load_en && ({1'b0, load_row} < c_ROWS)) begin
            grid_q[load_row] <= load_data;
          end
          row_q <= '0;
        end
        c_COMPUTE: begin
          shadow_q[row_q] <= w_next_row;
          row_q           <= (row_q == c_LAST) ? '0 : row_q + c_ONE;
        end
        c_COMMIT: begin
          grid_q    <= shadow_q;
          gen_q     <= gen_q + c_GEN_ONE;
          stable_q  <= (shadow_q == grid_q);
          extinct_q <= (shadow_q == '0);
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gol_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gol_engine
// Purpose  : Self-checking bench for gol_engine. Three instances share the
//            same stimulus: toroidal 16-bit counter, dead-edge 16-bit
//            counter, and toroidal 2-bit counter. A whole-grid life model
//            per edge mode predicts every committed generation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gol_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic       load_en = 1'b0;
  logic [2:0] load_row = '0;
  logic [7:0] load_data = '0;
  logic [2:0] rd_row = '0;

  logic        busy_a, done_a, stable_a, extinct_a;
  logic [7:0]  rd_a;
  logic [15:0] gen_a;
  logic        busy_b, done_b, stable_b, extinct_b;
  logic [7:0]  rd_b;
  logic [15:0] gen_b;
  logic        busy_c, done_c, stable_c, extinct_c;
  logic [7:0]  rd_c;
  logic [1:0]  gen_c;

  always #10 clk = ~clk;

  gol_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .step(step), .busy(busy_a), .done(done_a),
    .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .rd_row(rd_row), .rd_data(rd_a), .gen_count(gen_a),
    .stable(stable_a), .extinct(extinct_a));

  gol_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .step(step), .busy(busy_b), .done(done_b),
    .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .rd_row(rd_row), .rd_data(rd_b), .gen_count(gen_b),
    .stable(stable_b), .extinct(extinct_b));

  gol_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .step(step), .busy(busy_c), .done(done_c),
    .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .rd_row(rd_row), .rd_data(rd_c), .gen_count(gen_c),
    .stable(stable_c), .extinct(extinct_c));

  int checks = 0;
  int errors = 0;

  // Reference model: grid as 64 bits, cell (r,c) at bit r*8+c.
  logic [63:0] m1, m0;
  int          mgen;
  logic        ms1, me1, ms0, me0;

  function automatic logic [63:0] life(input logic [63:0] g, input bit wrap);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              cnt += int'(g[rr*8 + cc]);
          end
        end
        n[r*8 + c] = (cnt == 3) || (cnt == 2 && g[r*8 + c]);
      end
    end
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m1 = '0; m0 = '0; mgen = 0;
    ms1 = 0; me1 = 0; ms0 = 0; me0 = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic model_load(input int r, input logic [7:0] d);
    m1[r*8 +: 8] = d;
    m0[r*8 +: 8] = d;
  endtask

  task automatic load(input int r, input logic [7:0] d);
    load_en = 1'b1; load_row = 3'(r); load_data = d;
    tick;
    load_en = 1'b0;
    model_load(r, d);
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      chk($sformatf("%s.wrap_row%0d", tag, r),  32'(rd_a), 32'(m1[r*8 +: 8]));
      chk($sformatf("%s.dead_row%0d", tag, r),  32'(rd_b), 32'(m0[r*8 +: 8]));
      chk($sformatf("%s.gen2_row%0d", tag, r),  32'(rd_c), 32'(m1[r*8 +: 8]));
    end
    chk({tag, ".gen_a"},     32'(gen_a),     32'(mgen[15:0]));
    chk({tag, ".gen_b"},     32'(gen_b),     32'(mgen[15:0]));
    chk({tag, ".gen_c"},     32'(gen_c),     32'(mgen[1:0]));
    chk({tag, ".stable_a"},  32'(stable_a),  32'(ms1));
    chk({tag, ".extinct_a"}, 32'(extinct_a), 32'(me1));
    chk({tag, ".stable_b"},  32'(stable_b),  32'(ms0));
    chk({tag, ".extinct_b"}, 32'(extinct_b), 32'(me0));
    chk({tag, ".stable_c"},  32'(stable_c),  32'(ms1));
    chk({tag, ".busy_a"},    32'(busy_a),    32'd0);
  endtask

  // One generation. intf > 0 pulses step+load_en(row0=0xFF) at that compute
  // cycle; ld applies a load in the same cycle as step.
  task automatic do_step(input string tag, input int intf, input bit ld,
                         input int lrow, input logic [7:0] ldat);
    int          k;
    bit          seen;
    logic [63:0] n1, n0;
    if (ld) begin
      load_en = 1'b1; load_row = 3'(lrow); load_data = ldat;
    end
    step = 1'b1;
    tick;
    step = 1'b0; load_en = 1'b0;
    if (ld) model_load(lrow, ldat);
    chk({tag, ".busy_after_step"}, 32'(busy_a), 32'd1);
    seen = 0;
    for (k = 1; k <= 20; k++) begin
      if (k == intf) begin
        step = 1'b1; load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF;
      end
      if (k == 4) begin
        rd_row = 3'd3;
        #1;
        chk({tag, ".no_tear"}, 32'(rd_a), 32'(m1[3*8 +: 8]));
      end
      tick;
      step = 1'b0; load_en = 1'b0;
      if (done_a) begin
        seen = 1;
        break;
      end
    end
    chk({tag, ".done_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'd9);
    chk({tag, ".done_b"}, 32'(done_b), 32'd1);
    chk({tag, ".done_c"}, 32'(done_c), 32'd1);
    n1 = life(m1, 1'b1);
    n0 = life(m0, 1'b0);
    ms1 = (n1 == m1); me1 = (n1 == '0);
    ms0 = (n0 == m0); me0 = (n0 == '0);
    m1 = n1; m0 = n0;
    mgen++;
    check_all(tag);
    tick;
    chk({tag, ".done_one_cycle"}, 32'(done_a), 32'd0);
    chk({tag, ".idle_after"},     32'(busy_a), 32'd0);
  endtask

  initial begin
    int dn;
    model_reset();
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    chk("reset.done", 32'(done_a), 32'd0);
    check_all("reset");

    // Blinker on the torus
    load(3, 8'h1C);
    do_step("blink1", 0, 0, 0, 8'h00);
    rd_row = 3'd2; #1;
    chk("blink1.row2_const", 32'(rd_a), 32'h08);
    chk("blink1.stable_const", 32'(stable_a), 32'd0);
    do_step("blink2", 0, 0, 0, 8'h00);
    rd_row = 3'd3; #1;
    chk("blink2.row3_const", 32'(rd_a), 32'h1C);
    chk("blink2.gen_const", 32'(gen_a), 32'd2);

    // Block still life
    do_reset();
    load(0, 8'h03);
    load(1, 8'h03);
    do_step("block", 0, 0, 0, 8'h00);
    chk("block.stable_const", 32'(stable_a), 32'd1);
    chk("block.extinct_const", 32'(extinct_a), 32'd0);

    // Torus corners vs dead edges
    do_reset();
    load(0, 8'h81);
    load(7, 8'h01);
    do_step("corner", 0, 0, 0, 8'h00);
    rd_row = 3'd7; #1;
    chk("corner.row7_wrap", 32'(rd_a), 32'h81);
    chk("corner.extinct_dead", 32'(extinct_b), 32'd1);

    // Inputs ignored while busy
    do_reset();
    load(3, 8'h1C);
    do_step("busyin", 3, 0, 0, 8'h00);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done_a || busy_a) dn++;
    end
    chk("busyin.no_queued_step", 32'(dn), 32'd0);
    check_all("busyin_after");

    // Reset during compute
    do_reset();
    load(3, 8'h1C);
    step = 1'b1;
    tick;
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    model_reset();
    chk("abort.busy", 32'(busy_a), 32'd0);
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done_a || done_b || done_c) dn++;
    end
    chk("abort.no_done", 32'(dn), 32'd0);
    check_all("abort");

    // Load and step together, then generation counter wrap on GEN_W=2
    do_reset();
    do_step("ldstep", 0, 1, 5, 8'h07);
    rd_row = 3'd4; #1;
    chk("ldstep.row4_const", 32'(rd_a), 32'h02);
    do_step("wrap_s2", 0, 0, 0, 8'h00);
    do_step("wrap_s3", 0, 0, 0, 8'h00);
    do_step("wrap_s4", 0, 0, 0, 8'h00);
    chk("genwrap.gen_c_const", 32'(gen_c), 32'd0);
    chk("genwrap.gen_a_const", 32'(gen_a), 32'd4);

    // Random soups
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 8; r++) load(r, 8'($urandom));
      for (int s = 0; s < 3; s++) do_step($sformatf("rand%0d_%0d", it, s), 0, 0, 0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gol_engine.md
Name: gol_engine

Overview:
- Parametrised Conway Game-of-Life generation engine; successor to the fixed 8x8 life core behind the LED-matrix top.
- Holds a ROWS x COLS cell grid and computes one generation per step request, one row per clock, into a shadow buffer, then commits atomically.
- Supports toroidal or dead-edge boundaries and reports stable/extinct status.
- Sits between seed loader/buttons and the LED display driver, which reads rows through rd_row/rd_data.

Parameters:
- ROWS, 8, grid height; must be >= 3.
- COLS, 8, grid width in bits per row; must be >= 3.
- WRAP, 1, 1 = toroidal edges, 0 = cells outside the grid are dead.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- step  in  1  request one generation; sampled only in IDLE.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse, first cycle the new generation is readable.
- load_en  in  1  write load_data into row load_row; IDLE only.
- load_row  in  $clog2(ROWS)  row index for load.
- load_data  in  COLS  row contents; bit c = column c, 1 = alive.
- rd_row  in  $clog2(ROWS)  display read row index.
- rd_data  out  COLS  combinational read of committed grid[rd_row]; 0 if rd_row >= ROWS.
- gen_count  out  GEN_W  committed generations, wraps modulo 2^GEN_W.
- stable  out  1  last committed generation equal to its predecessor.
- extinct  out  1  committed grid all zero after last step.

Behaviour:
- Reset (rst_n low at an edge) clears:
  - grid and shadow buffer to 0.
  - gen_count, done, stable, extinct to 0.
  - state to IDLE, so busy = 0.
- Reset mid-compute aborts the step: no done, grid cleared.
- FSM states IDLE, COMPUTE, COMMIT.
- IDLE:
  - load_en with load_row < ROWS writes the row at the edge.
  - load_row >= ROWS is ignored.
  - step high at edge E0 moves to COMPUTE with row_idx = 0.
  - load_en and step together: the load is written at E0 and the computation uses the loaded row.
- COMPUTE:
  - At edge E(k+1), shadow[k] <= next-state of row k. It is computed combinationally from grid rows k-1, k, k+1.
  - row_idx increments.
  - After row ROWS-1, i.e. at E_ROWS, move to COMMIT.
- COMMIT, at edge E_ROWS+1:
  - grid <= shadow; gen_count++.
  - stable <= (shadow == grid); extinct <= (shadow == 0).
  - done <= 1 for exactly one cycle; state returns to IDLE.
- Latency: done is high in the cycle after edge E_ROWS+1, i.e. ROWS+1 edges after step is sampled (9 for 8x8). busy is high ROWS+1 cycles.
- step and load_en are ignored while busy; step is not queued.
- Cell rule B3/S23:
  - Neighbour count is 4-bit unsigned, 0..8, over the 8 surrounding cells.
  - Next state is alive iff count == 3, or (count == 2 and cell alive).
- Edge handling:
  - WRAP=1: row index wraps (row -1 -> ROWS-1, row ROWS -> 0); column index wraps likewise.
  - WRAP=0: out-of-range neighbours count as 0.
- Grid is updated only at COMMIT; rd_data shows the old generation throughout COMPUTE, so there is no tearing.
- stable and extinct hold until the next COMMIT or reset; loads do not modify them.

Test Plan:
1. Blinker, 8x8, WRAP=1:
   - Stimulus: load row3 = 0x1C, then step.
   - Required: done exactly 9 cycles after step edge; rows 2,3,4 = 0x08, others 0; gen_count = 1; stable = 0.
   - Second step: row3 = 0x1C, rows 2 and 4 = 0, gen_count = 2.
2. Block still life:
   - Stimulus: load rows 0 and 1 = 0x03, then step.
   - Required: grid unchanged, stable = 1, extinct = 0.
3. Torus corners:
   - Stimulus: WRAP=1, row0 = 0x81, row7 = 0x01, then step.
   - Required: row0 = 0x81, row7 = 0x81.
   - Same load with WRAP=0: all rows 0, extinct = 1.
4. Ignored inputs while busy:
   - Stimulus: issue step, then pulse step and load_en (row0 = 0xFF) at compute cycle 3.
   - Required: single done pulse, gen_count = 1, row0 unaffected by the load.
5. Reset mid-operation:
   - Stimulus: blinker loaded, step, rst_n low for one edge at compute cycle 4.
   - Required: busy = 0, done never asserts, all rd_data = 0, gen_count = 0.
6. Load+step and wrap:
   - Stimulus: in the same IDLE cycle, load row5 = 0x07 and step.
   - Required: result is the vertical blinker at column 1 (rows 4,5,6 = 0x02).
   - gen_count wrap: with GEN_W = 2, after 4 steps gen_count = 0.
